// File: rtl/vta_axil_csr.sv
// vta_axil_csr: AXI4-Lite control/status register file for the VTA core.
// The host programs the instruction count and DRAM pointers, then writes START.
// The block pulses launch, tracks busy/done, and counts execution cycles.
module vta_axil_csr #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_PTRS   = 6
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           s_axi_awvalid,
    output logic                           s_axi_awready,
    input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
    input  logic                           s_axi_wvalid,
    output logic                           s_axi_wready,
    input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]        s_axi_wstrb,
    output logic                           s_axi_bvalid,
    input  logic                           s_axi_bready,
    output logic [1:0]                     s_axi_bresp,
    input  logic                           s_axi_arvalid,
    output logic                           s_axi_arready,
    input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
    output logic                           s_axi_rvalid,
    input  logic                           s_axi_rready,
    output logic [DATA_WIDTH-1:0]          s_axi_rdata,
    output logic [1:0]                     s_axi_rresp,
    output logic                           launch,
    input  logic                           finish,
    output logic                           busy,
    output logic [DATA_WIDTH-1:0]          vals0,
    output logic [NUM_PTRS*DATA_WIDTH-1:0] ptrs
);
    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam logic [IDX_W-1:0] IDX_CTRL = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_ECNT = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_VALS = IDX_W'(2);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(2 + NUM_PTRS);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t                state, state_nxt;
    logic                  done, done_nxt, launch_nxt;
    logic [DATA_WIDTH-1:0] ecnt;
    logic [DATA_WIDTH-1:0] vals0_q;
    logic [DATA_WIDTH-1:0] ptr_q [NUM_PTRS];
    logic [DATA_WIDTH-1:0] rd_data;
    logic [1:0]            rd_resp;

    // Byte-lane merge of new write data into an existing register value.
    function automatic logic [DATA_WIDTH-1:0] apply_strb(
        input logic [DATA_WIDTH-1:0]   old_v,
        input logic [DATA_WIDTH-1:0]   new_v,
        input logic [DATA_WIDTH/8-1:0] strb
    );
        logic [DATA_WIDTH-1:0] r;
        r = old_v;
        for (int b = 0; b < DATA_WIDTH/8; b++)
            if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
        return r;
    endfunction

    // Cycle counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [DATA_WIDTH-1:0] sat_inc(input logic [DATA_WIDTH-1:0] v);
        return (&v) ? v : v + DATA_WIDTH'(1);
    endfunction

    // Address byte offsets within a word carry no meaning here.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    logic [IDX_W-1:0] wr_idx, rd_idx;
    logic             wr_fire, rd_fire, wr_mapped, ctrl_wr, idle_wr;

    assign wr_idx    = s_axi_awaddr[ADDR_WIDTH-1:2];
    assign rd_idx    = s_axi_araddr[ADDR_WIDTH-1:2];
    // AW and W are taken only as a pair, and never while a response is pending.
    assign wr_fire   = s_axi_awvalid & s_axi_wvalid & ~s_axi_bvalid;
    assign rd_fire   = s_axi_arvalid & ~s_axi_rvalid;
    assign wr_mapped = (wr_idx <= IDX_LAST);
    assign ctrl_wr   = wr_fire & (wr_idx == IDX_CTRL) & s_axi_wstrb[0];
    assign idle_wr   = wr_fire & (state == IDLE);

    assign s_axi_awready = wr_fire;
    assign s_axi_wready  = wr_fire;
    assign s_axi_arready = rd_fire;
    assign busy          = (state == BUSY);
    assign vals0         = vals0_q;

    for (genvar k = 0; k < NUM_PTRS; k++) begin : g_ptr
        assign ptrs[DATA_WIDTH*k +: DATA_WIDTH] = ptr_q[k];
    end

    // FSM next state: START from IDLE launches; finish in BUSY wins over any CTRL write.
    always_comb begin
        state_nxt  = state;
        done_nxt   = done;
        launch_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (ctrl_wr) begin
                    done_nxt = 1'b0;
                    if (s_axi_wdata[0]) begin
                        state_nxt  = BUSY;
                        launch_nxt = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (finish) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state, done flag and the one-cycle launch pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            done   <= 1'b0;
            launch <= 1'b0;
        end else begin
            state  <= state_nxt;
            done   <= done_nxt;
            launch <= launch_nxt;
        end
    end

    // Cycle counter and parameter registers; host writes land only while IDLE.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ecnt    <= '0;
            vals0_q <= '0;
            for (int k = 0; k < NUM_PTRS; k++) ptr_q[k] <= '0;
        end else if (state == BUSY) begin
            ecnt <= sat_inc(ecnt);
        end else if (launch_nxt) begin
            ecnt <= '0;
        end else if (idle_wr) begin
            if (wr_idx == IDX_ECNT) ecnt <= apply_strb(ecnt, s_axi_wdata, s_axi_wstrb);
            if (wr_idx == IDX_VALS) vals0_q <= apply_strb(vals0_q, s_axi_wdata, s_axi_wstrb);
            for (int k = 0; k < NUM_PTRS; k++)
                if (wr_idx == IDX_W'(3 + k))
                    ptr_q[k] <= apply_strb(ptr_q[k], s_axi_wdata, s_axi_wstrb);
        end
    end

    // Write response: raised after an accepted pair, held until bready.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= RESP_OKAY;
        end else if (wr_fire) begin
            s_axi_bvalid <= 1'b1;
            s_axi_bresp  <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
        end else if (s_axi_bready) begin
            s_axi_bvalid <= 1'b0;
        end
    end

    // Read mux over the current (pre-write) register contents.
    always_comb begin
        rd_data = '0;
        rd_resp = RESP_OKAY;
        if (rd_idx == IDX_CTRL)      rd_data = {{(DATA_WIDTH-2){1'b0}}, done, busy};
        else if (rd_idx == IDX_ECNT) rd_data = ecnt;
        else if (rd_idx == IDX_VALS) rd_data = vals0_q;
        else if (rd_idx > IDX_LAST)  rd_resp = RESP_SLVERR;
        for (int k = 0; k < NUM_PTRS; k++)
            if (rd_idx == IDX_W'(3 + k)) rd_data = ptr_q[k];
    end

    // Read response: registered data/resp, held until rready.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s_axi_rvalid <= 1'b0;
            s_axi_rdata  <= '0;
            s_axi_rresp  <= RESP_OKAY;
        end else if (rd_fire) begin
            s_axi_rvalid <= 1'b1;
            s_axi_rdata  <= rd_data;
            s_axi_rresp  <= rd_resp;
        end else if (s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
        end
    end
endmodule
